// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the B-type immediate helper, also intended
// for reuse by the execute-stage branch unit.
package fetch_pkg;
    localparam int          INSTR_W = 32;
    localparam int          PC_STEP = 4;
    localparam logic [31:0] RV_NOP  = 32'h0000_0013;

    // imm[12:1] -> sign-extended byte offset (imm << 1)
    function automatic logic signed [31:0] b_offset(input logic [11:0] imm);
        return {{19{imm[11]}}, imm, 1'b0};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one
// cycle. Output reads as zero while empty so the head is never stale data.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, credit-limited imem requests,
// redirect handling with stale-response dropping, and the fetch queue.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FQ_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_base,
    input  logic [11:0]        redirect_imm,
    output logic               ifq_valid,
    input  logic               ifq_ready,
    output logic [XLEN-1:0]    ifq_pc,
    output logic [INSTR_W-1:0] ifq_instr,
    output logic               fetch_misalign
);
    localparam int CW = $clog2(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW:0]     inflight_q, inflight_d;
    logic [CW:0]     drop_cnt_q, drop_cnt_d;
    logic            misalign_q, misalign_d;

    logic [CW:0]           occ;
    logic                  q_empty;
    logic                  q_full;
    logic [CW+1:0]         credit_used;
    logic                  req_fire;
    logic                  push;
    logic [CW:0]           rsp_one;
    logic [CW:0]           req_one;
    logic signed [31:0]    boff;
    logic [XLEN-1:0]       target_raw;
    logic [XLEN-1:0]       target;
    logic [XLEN+INSTR_W-1:0] head;

    assign credit_used    = {1'b0, occ} + {1'b0, inflight_q};
    assign imem_req_valid = !rst && !redirect_valid && !q_full
                            && (credit_used < (CW+2)'(FQ_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_one        = (CW+1)'(imem_rsp_valid);
    assign req_one        = (CW+1)'(req_fire);

    assign boff       = b_offset(redirect_imm);
    assign target_raw = redirect_base + XLEN'(boff);
    assign target     = target_raw & ~XLEN'(3);

    assign push = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

    // drop_cnt tracks the stale subset of inflight, so a redirect marks every
    // outstanding request stale except a response landing this very cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        misalign_d = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            inflight_d = inflight_q - rsp_one;
            drop_cnt_d = inflight_q - rsp_one;
            misalign_d = target_raw[1];
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - (CW+1)'(1);
                else                  rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
            end
            inflight_d = inflight_q + req_one - rsp_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_VECTOR;
            rsp_pc_q   <= RESET_VECTOR;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_queue #(
        .WIDTH (XLEN + INSTR_W),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (ifq_valid && ifq_ready),
        .flush_i (redirect_valid),
        .wdata_i ({rsp_pc_q, imem_rsp_data}),
        .rdata_o (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (occ)
    );

    assign ifq_valid      = !q_empty;
    assign ifq_pc         = head[XLEN+INSTR_W-1:INSTR_W];
    assign ifq_instr      = head[INSTR_W-1:0];
    assign fetch_misalign = misalign_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: an in-order memory model plus a
// reference of the expected decode stream (PC sequence restarted by redirects).
module tb_fetch_pc_unit;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [11:0] redirect_imm;
    logic        ifq_valid;
    logic        ifq_ready;
    logic [31:0] ifq_pc;
    logic [31:0] ifq_instr;
    logic        fetch_misalign;

    fetch_pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_base(redirect_base),
        .redirect_imm(redirect_imm),
        .ifq_valid(ifq_valid), .ifq_ready(ifq_ready),
        .ifq_pc(ifq_pc), .ifq_instr(ifq_instr),
        .fetch_misalign(fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          last_rdy = -1;
    int          acc_cnt  = 0;
    int          occ;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    bit          exp_mis;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h13;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        occ        = 0;
        exp_pc     = RV;
        exp_req_pc = RV;
        exp_mis    = 0;
        last_rdy   = -1;
    endtask

    task automatic drive_idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_base  = '0;
        redirect_imm   = '0;
        ifq_ready      = 1'b0;
    endtask

    task automatic cycle(input bit redir, input logic [31:0] base, input logic [11:0] imm,
                         input bit rq_rdy, input bit ifq_rdy);
        bit          rsp_v, exp_rv, req, deq;
        logic [31:0] t;
        int          off;
        mreq_t       m;
        @(negedge clk);
        rsp_v          = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc);
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_v ? memfn(mem_q[0].addr) : 32'hDEAD_BEEF;
        imem_req_ready = rq_rdy;
        ifq_ready      = ifq_rdy;
        redirect_valid = redir;
        redirect_base  = base;
        redirect_imm   = imm;
        #1;
        exp_rv = !redir && (occ + mem_q.size() < DEPTH);
        n_checks++;
        if (imem_req_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
        n_checks++;
        if (ifq_valid !== (occ > 0)) begin
            n_fail++;
            $display("FAIL ifq_valid cyc=%0d got=%b exp=%b", cyc, ifq_valid, occ > 0);
        end
        n_checks++;
        if (fetch_misalign !== exp_mis) begin
            n_fail++;
            $display("FAIL misalign cyc=%0d got=%b exp=%b", cyc, fetch_misalign, exp_mis);
        end
        if (exp_rv) begin
            n_checks++;
            if (imem_req_addr !== exp_req_pc) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_pc);
            end
        end
        deq = (occ > 0) && ifq_rdy;
        if (deq) begin
            n_checks++;
            if (ifq_pc !== exp_pc || ifq_instr !== memfn(exp_pc)) begin
                n_fail++;
                $display("FAIL ifq_head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, ifq_pc, ifq_instr, exp_pc, memfn(exp_pc));
            end
        end
        if (imem_req_valid && rq_rdy) acc_cnt++;
        req = exp_rv && rq_rdy;
        if (rsp_v) begin
            m = mem_q.pop_front();
            if (!m.stale && !redir) occ++;
        end
        if (deq) begin
            occ--;
            exp_pc += 4;
        end
        exp_mis = 0;
        if (redir) begin
            off = $signed(imm);
            off = off * 2;
            t   = base + off;
            exp_mis    = t[1];
            t          = t & ~32'h3;
            occ        = 0;
            exp_pc     = t;
            exp_req_pc = t;
            foreach (mem_q[i]) mem_q[i].stale = 1;
        end else if (req) begin
            m.addr  = imem_req_addr;
            m.rdy   = (cyc + lat > last_rdy) ? cyc + lat : last_rdy;
            m.stale = 0;
            last_rdy = m.rdy;
            mem_q.push_back(m);
            exp_req_pc += 4;
        end
        cyc++;
    endtask

    task automatic fresh_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        n_checks++; if (ifq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ifq_valid got=%b exp=0", ifq_valid); end
        n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got=%b exp=0", fetch_misalign); end
        n_checks++; if (imem_req_addr !== RV) begin n_fail++; $display("FAIL rst_req_addr got=%h exp=%h", imem_req_addr, RV); end
        n_checks++; if (ifq_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ifq_pc got=%h exp=0", ifq_pc); end
        n_checks++; if (ifq_instr !== 32'h0) begin n_fail++; $display("FAIL rst_ifq_instr got=%h exp=0", ifq_instr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        lat = 1;
        repeat (20) cycle(0, '0, '0, 1, 1);
    endtask

    task automatic test_backpressure();
        fresh_reset();
        lat = 1;
        acc_cnt = 0;
        repeat (8) cycle(0, '0, '0, 1, 0);
        n_checks++;
        if (acc_cnt !== 4) begin
            n_fail++;
            $display("FAIL bp_accepted got=%0d exp=4", acc_cnt);
        end
        repeat (12) cycle(0, '0, '0, 1, 1);
    endtask

    task automatic test_redirect_drop();
        fresh_reset();
        lat = 3;
        repeat (3) cycle(0, '0, '0, 1, 1);
        cycle(1, 32'h200, 12'hFF8, 1, 1);
        repeat (14) cycle(0, '0, '0, 1, 1);
    endtask

    task automatic test_misalign();
        lat = 1;
        cycle(1, 32'h200, 12'h001, 1, 1);
        repeat (8) cycle(0, '0, '0, 1, 1);
    endtask

    task automatic test_wrap();
        lat = 1;
        cycle(1, 32'hFFFF_FFF8, 12'h000, 1, 1);
        repeat (30) cycle(0, '0, '0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    endtask

    task automatic test_back_to_back();
        lat = 2;
        repeat (4) cycle(0, '0, '0, 1, 1);
        cycle(1, 32'h400, 12'h010, 1, 1);
        cycle(1, 32'h800, 12'h7FE, 1, 1);
        repeat (12) cycle(0, '0, '0, 1, 1);
    endtask

    task automatic test_random();
        bit          r;
        logic [31:0] b;
        logic [11:0] im;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) lat = $urandom_range(1, 4);
            r  = ($urandom_range(0, 15) == 0);
            b  = $urandom;
            im = 12'($urandom);
            cycle(r, b, im, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_reset_mid();
        fresh_reset();
        lat = 3;
        repeat (5) cycle(0, '0, '0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        n_checks++; if (ifq_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ifq_valid got=%b exp=0", ifq_valid); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req_valid got=%b exp=0", imem_req_valid); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        repeat (10) cycle(0, '0, '0, 1, 1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
